// File: rtl/axi4l_sram_pkg.sv
// Shared types and default MMIO constants for the AXI4-Lite SRAM slave.
package axi4l_sram_pkg;

   // AXI response codes used by this slave
   typedef enum logic [1:0] {
      OKAY   = 2'b00,
      SLVERR = 2'b10
   } resp_t;

   // Write channel states: which halves of a write are held, or response pending
   typedef enum logic [1:0] {
      W_IDLE,
      W_HAVE_AW,
      W_HAVE_W,
      W_RESP
   } wr_state_t;

   localparam logic [31:0] DEF_CONSOLE_ADDR = 32'h1000_0000;
   localparam logic [31:0] DEF_PASS_ADDR    = 32'h2000_0000;
   localparam logic [31:0] DEF_PASS_MAGIC   = 32'd123456789;

   // Read-buffer entries are sized for the widest supported bus
   localparam int unsigned MAX_DATA_W = 64;

   typedef struct packed {
      logic [MAX_DATA_W-1:0] data;
      resp_t                 resp;
   } rd_entry_t;

   // Collecting state implied by the holding-register flags
   function automatic wr_state_t hold_state(input logic aw_full, input logic w_full);
      if (aw_full) return W_HAVE_AW;
      if (w_full)  return W_HAVE_W;
      return W_IDLE;
   endfunction

endpackage

// File: rtl/axi4l_rd_fifo.sv
// Synchronous FIFO for read responses; any DEPTH >= 2, payload given by type T.
module axi4l_rd_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter type         T     = logic
) (
   input  logic                   clk,
   input  logic                   resetn,
   input  logic                   push,
   input  T                       push_data,
   input  logic                   pop,
   output T                       pop_data,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH) + 1;

   T              mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0] cnt_q;
   logic          push_ok, pop_ok;

   assign full     = (cnt_q == CW'(DEPTH));
   assign empty    = (cnt_q == '0);
   assign count    = cnt_q;
   assign pop_data = mem_q[rd_ptr_q];
   assign push_ok  = push && !full;
   assign pop_ok   = pop && !empty;

   // Pointers wrap explicitly so non-power-of-two depths work
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (push_ok) wr_ptr_q <= (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
         if (pop_ok)  rd_ptr_q <= (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
         if (push_ok && !pop_ok)      cnt_q <= cnt_q + CW'(1);
         else if (pop_ok && !push_ok) cnt_q <= cnt_q - CW'(1);
      end
   end

   // Payload storage needs no reset
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= push_data;
   end

endmodule

// File: rtl/axi4l_sram_slave.sv
// AXI4-Lite slave RAM with console and test-pass MMIO words.
// Optional: define AXI4L_SRAM_RAND_STALL_EN for pseudo-random handshake stalls.
module axi4l_sram_slave
   import axi4l_sram_pkg::*;
#(
   parameter int unsigned DATA_W       = 32,
   parameter int unsigned ADDR_W       = 32,
   parameter int unsigned MEM_BYTES    = 131072,
   parameter int unsigned RD_LAT       = 1,
   parameter int unsigned RD_DEPTH     = 4,
   parameter logic [31:0] CONSOLE_ADDR = DEF_CONSOLE_ADDR,
   parameter logic [31:0] PASS_ADDR    = DEF_PASS_ADDR,
   parameter logic [31:0] PASS_MAGIC   = DEF_PASS_MAGIC
) (
   input  logic                clk,
   input  logic                resetn,
   input  logic                awvalid,
   output logic                awready,
   input  logic [ADDR_W-1:0]   awaddr,
   input  logic [2:0]          awprot,
   input  logic                wvalid,
   output logic                wready,
   input  logic [DATA_W-1:0]   wdata,
   input  logic [DATA_W/8-1:0] wstrb,
   output logic                bvalid,
   input  logic                bready,
   output logic [1:0]          bresp,
   input  logic                arvalid,
   output logic                arready,
   input  logic [ADDR_W-1:0]   araddr,
   input  logic [2:0]          arprot,
   output logic                rvalid,
   input  logic                rready,
   output logic [DATA_W-1:0]   rdata,
   output logic [1:0]          rresp,
   output logic                console_valid,
   output logic [7:0]          console_char,
   output logic                tests_passed,
   output logic                err_oob
);

   localparam int unsigned STRB_W = DATA_W / 8;
   localparam int unsigned BW     = $clog2(STRB_W);
   localparam int unsigned WORDS  = MEM_BYTES / STRB_W;
   localparam int unsigned IDX_W  = $clog2(WORDS);
   localparam int unsigned CNT_W  = $clog2(RD_DEPTH) + 1;
   localparam logic [ADDR_W-1:0] LOW_MASK  = ADDR_W'(STRB_W - 1);
   localparam logic [ADDR_W-1:0] CON_ALIGN = ADDR_W'(CONSOLE_ADDR) & ~LOW_MASK;
   localparam logic [ADDR_W-1:0] PAS_ALIGN = ADDR_W'(PASS_ADDR) & ~LOW_MASK;

   logic [DATA_W-1:0] mem [WORDS];

   logic [4:0] stall;  // [0] aw, [1] w, [2] ar, [3] r pop, [4] write commit

   // ---------------- write path ----------------
   wr_state_t           wr_state_q, wr_state_d;
   resp_t               bresp_q, bresp_d;
   logic                aw_full_q, aw_full_d, w_full_q, w_full_d;
   logic [ADDR_W-1:0]   aw_addr_q;
   logic [DATA_W-1:0]   w_data_q;
   logic [STRB_W-1:0]   w_strb_q;
   logic                aw_hs, w_hs, commit;
   logic                wr_in_ram, wr_is_con, wr_is_pass, wr_ok;
   logic                console_valid_q, tests_passed_q, err_oob_q;
   logic [7:0]          console_char_q;

   assign awready    = !aw_full_q && !stall[0];
   assign wready     = !w_full_q && !stall[1];
   assign aw_hs      = awvalid && awready;
   assign w_hs       = wvalid && wready;
   assign bvalid     = (wr_state_q == W_RESP);
   assign bresp      = bresp_q;
   assign wr_in_ram  = aw_addr_q < ADDR_W'(MEM_BYTES);
   assign wr_is_con  = (aw_addr_q & ~LOW_MASK) == CON_ALIGN;
   assign wr_is_pass = (aw_addr_q & ~LOW_MASK) == PAS_ALIGN;
   assign wr_ok      = wr_in_ram || wr_is_con || wr_is_pass;
   // A held pair may not commit until the previous response has been taken
   assign commit     = aw_full_q && w_full_q && (wr_state_q != W_RESP) && !stall[4];

   // Write FSM next state, holding flags and response code
   always_comb begin
      aw_full_d  = aw_full_q || aw_hs;
      w_full_d   = w_full_q || w_hs;
      wr_state_d = wr_state_q;
      bresp_d    = bresp_q;
      if (commit) begin
         aw_full_d  = 1'b0;
         w_full_d   = 1'b0;
         wr_state_d = W_RESP;
         bresp_d    = wr_ok ? OKAY : SLVERR;
      end else if (wr_state_q == W_RESP) begin
         if (bready) wr_state_d = hold_state(aw_full_d, w_full_d);
      end else begin
         wr_state_d = hold_state(aw_full_d, w_full_d);
      end
   end

   // ---------------- read path ----------------
   logic [CNT_W-1:0]   outst_q;
   logic               ar_hs, r_hs, rd_ok;
   rd_entry_t          ar_ent, fifo_head;
   logic [RD_LAT-1:0]  st_vld_q;
   rd_entry_t          st_ent_q [RD_LAT];
   logic               fifo_full, fifo_empty;
   logic [CNT_W-1:0]   fifo_count;

   assign arready = (outst_q < CNT_W'(RD_DEPTH)) && !stall[2];
   assign ar_hs   = arvalid && arready;
   assign r_hs    = rvalid && rready;
   assign rd_ok   = (ar_ent.resp == OKAY);
   assign rdata   = fifo_empty ? '0 : fifo_head.data[DATA_W-1:0];
   assign rresp   = fifo_empty ? OKAY : fifo_head.resp;

   // Read decode; the RAM is sampled before any same-edge write lands
   always_comb begin
      ar_ent = '{data: '0, resp: OKAY};
      if (araddr < ADDR_W'(MEM_BYTES)) begin
         ar_ent.data = MAX_DATA_W'(mem[araddr[BW +: IDX_W]]);
      end else if ((araddr & ~LOW_MASK) == PAS_ALIGN) begin
         ar_ent.data = MAX_DATA_W'(tests_passed_q);
      end else if ((araddr & ~LOW_MASK) != CON_ALIGN) begin
         ar_ent.resp = SLVERR;
      end
   end

   // Control state for both channels and sticky status
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_state_q      <= W_IDLE;
         bresp_q         <= OKAY;
         aw_full_q       <= 1'b0;
         w_full_q        <= 1'b0;
         aw_addr_q       <= '0;
         w_data_q        <= '0;
         w_strb_q        <= '0;
         console_valid_q <= 1'b0;
         console_char_q  <= '0;
         tests_passed_q  <= 1'b0;
         err_oob_q       <= 1'b0;
         outst_q         <= '0;
         st_vld_q        <= '0;
      end else begin
         wr_state_q <= wr_state_d;
         bresp_q    <= bresp_d;
         aw_full_q  <= aw_full_d;
         w_full_q   <= w_full_d;
         if (aw_hs) aw_addr_q <= awaddr;
         if (w_hs) begin
            w_data_q <= wdata;
            w_strb_q <= wstrb;
         end
         console_valid_q <= commit && wr_is_con && !wr_in_ram;
         if (commit && wr_is_con && !wr_in_ram) console_char_q <= w_data_q[7:0];
         if (commit && wr_is_pass && !wr_in_ram && (w_data_q[31:0] == PASS_MAGIC))
            tests_passed_q <= 1'b1;
         if ((commit && !wr_ok) || (ar_hs && !rd_ok)) err_oob_q <= 1'b1;
         if (ar_hs && !r_hs)      outst_q <= outst_q + CNT_W'(1);
         else if (r_hs && !ar_hs) outst_q <= outst_q - CNT_W'(1);
         st_vld_q[0] <= ar_hs;
         for (int k = 1; k < RD_LAT; k++) st_vld_q[k] <= st_vld_q[k-1];
      end
   end

   // Read latency pipeline payload
   always_ff @(posedge clk) begin
      st_ent_q[0] <= ar_ent;
      for (int k = 1; k < RD_LAT; k++) st_ent_q[k] <= st_ent_q[k-1];
   end

   // Byte-strobed RAM write at commit
   always_ff @(posedge clk) begin
      if (commit && wr_in_ram) begin
         for (int b = 0; b < STRB_W; b++) begin
            if (w_strb_q[b]) mem[aw_addr_q[BW +: IDX_W]][b*8 +: 8] <= w_data_q[b*8 +: 8];
         end
      end
   end

   axi4l_rd_fifo #(
      .DEPTH (RD_DEPTH),
      .T     (rd_entry_t)
   ) u_rd_fifo (
      .clk       (clk),
      .resetn    (resetn),
      .push      (st_vld_q[RD_LAT-1]),
      .push_data (st_ent_q[RD_LAT-1]),
      .pop       (r_hs),
      .pop_data  (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

`ifdef AXI4L_SRAM_RAND_STALL_EN
   logic [63:0] rng_q, rng_d;
   logic        rv_hold_q;

   // xorshift64 step
   always_comb begin
      rng_d = rng_q ^ (rng_q << 13);
      rng_d = rng_d ^ (rng_d >> 7);
      rng_d = rng_d ^ (rng_d << 17);
   end

   // Stall generator; rv_hold_q keeps a presented response visible until taken
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rng_q     <= 64'd88172645463325252;
         rv_hold_q <= 1'b0;
      end else begin
         rng_q     <= rng_d;
         rv_hold_q <= rvalid && !rready;
      end
   end

   assign stall  = rng_q[4:0];
   assign rvalid = !fifo_empty && (!stall[3] || rv_hold_q);
`else
   assign stall  = '0;
   assign rvalid = !fifo_empty;
`endif

   assign console_valid = console_valid_q;
   assign console_char  = console_char_q;
   assign tests_passed  = tests_passed_q;
   assign err_oob       = err_oob_q;

   logic unused_bits;
   assign unused_bits = ^{awprot, arprot, fifo_head.data, fifo_full, fifo_count};

endmodule

// File: tb/tb_axi4l_sram_slave.sv
// Directed bench for axi4l_sram_slave with default parameters.
module tb_axi4l_sram_slave;

   logic        clk = 1'b0;
   logic        resetn;
   logic        awvalid, awready, wvalid, wready, bvalid, bready;
   logic        arvalid, arready, rvalid, rready;
   logic [31:0] awaddr, wdata, araddr, rdata;
   logic [3:0]  wstrb;
   logic [2:0]  awprot, arprot;
   logic [1:0]  bresp, rresp;
   logic        console_valid, tests_passed, err_oob;
   logic [7:0]  console_char;

   int checks = 0;
   int errors = 0;
   int con_cnt = 0;
   logic [7:0] con_last = 8'h00;

   axi4l_sram_slave dut (
      .clk           (clk),
      .resetn        (resetn),
      .awvalid       (awvalid),
      .awready       (awready),
      .awaddr        (awaddr),
      .awprot        (awprot),
      .wvalid        (wvalid),
      .wready        (wready),
      .wdata         (wdata),
      .wstrb         (wstrb),
      .bvalid        (bvalid),
      .bready        (bready),
      .bresp         (bresp),
      .arvalid       (arvalid),
      .arready       (arready),
      .araddr        (araddr),
      .arprot        (arprot),
      .rvalid        (rvalid),
      .rready        (rready),
      .rdata         (rdata),
      .rresp         (rresp),
      .console_valid (console_valid),
      .console_char  (console_char),
      .tests_passed  (tests_passed),
      .err_oob       (err_oob)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (console_valid) begin
         con_cnt  = con_cnt + 1;
         con_last = console_char;
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic do_write(input string tag, input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input logic [1:0] exp_resp);
      bit aw_done, w_done, aw_take, w_take;
      logic [1:0] resp;
      int lat;
      aw_done = 0; w_done = 0; resp = 2'b11; lat = -1;
      awaddr = addr; wdata = data; wstrb = strb; awvalid = 1'b1; wvalid = 1'b1;
      for (int i = 0; i < 100 && !(aw_done && w_done); i++) begin
         aw_take = awvalid && awready;
         w_take  = wvalid && wready;
         @(negedge clk);
         if (aw_take) begin awvalid = 1'b0; aw_done = 1; end
         if (w_take)  begin wvalid = 1'b0;  w_done = 1;  end
      end
      awvalid = 1'b0; wvalid = 1'b0;
      bready = 1'b1;
      for (int i = 0; i < 100; i++) begin
         if (bvalid) begin resp = bresp; lat = i; break; end
         @(negedge clk);
      end
      @(negedge clk);
      bready = 1'b0;
      check({tag, "_bresp"}, 64'(resp), 64'(exp_resp));
      check({tag, "_blat"}, 64'(lat), 64'd1);
   endtask

   task automatic do_read(input string tag, input logic [31:0] addr, input logic [31:0] exp_data,
                          input logic [1:0] exp_resp);
      bit done;
      logic [31:0] data;
      logic [1:0]  resp;
      int lat;
      done = 0; data = 32'hFFFF_FFFF; resp = 2'b11; lat = -1;
      araddr = addr; arvalid = 1'b1;
      for (int i = 0; i < 100 && !done; i++) begin
         done = arready;
         @(negedge clk);
         if (done) arvalid = 1'b0;
      end
      arvalid = 1'b0;
      rready = 1'b1;
      for (int i = 0; i < 100; i++) begin
         if (rvalid) begin data = rdata; resp = rresp; lat = i; break; end
         @(negedge clk);
      end
      @(negedge clk);
      rready = 1'b0;
      check({tag, "_rdata"}, 64'(data), 64'(exp_data));
      check({tag, "_rresp"}, 64'(resp), 64'(exp_resp));
      check({tag, "_rlat"}, 64'(lat), 64'd1);
   endtask

   initial begin
      int base;
      int waited;
      resetn = 1'b0;
      awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
      awaddr = '0; wdata = '0; wstrb = '0; araddr = '0; awprot = '0; arprot = '0;
      repeat (2) @(negedge clk);

      // Reset values
      check("rst_readies", 64'({awready, wready, arready}), 64'b111);
      check("rst_valids", 64'({bvalid, rvalid, console_valid}), 64'b000);
      check("rst_resps", 64'({bresp, rresp}), 64'h0);
      check("rst_rdata", 64'(rdata), 64'h0);
      check("rst_status", 64'({console_char, tests_passed, err_oob}), 64'h0);
      resetn = 1'b1;
      @(negedge clk);

      // Full-word write and read back, plus unaligned read
      do_write("w100", 32'h100, 32'hDEADBEEF, 4'hF, 2'b00);
      do_read("r100", 32'h100, 32'hDEADBEEF, 2'b00);
      do_read("r102", 32'h102, 32'hDEADBEEF, 2'b00);

      // Byte-strobed partial write
      do_write("w104a", 32'h104, 32'h11223344, 4'hF, 2'b00);
      do_write("w104b", 32'h104, 32'h000000AA, 4'b0001, 2'b00);
      do_read("r104", 32'h104, 32'h112233AA, 2'b00);
      do_write("w104c", 32'h104, 32'h55000000, 4'b1000, 2'b00);
      do_read("r104c", 32'h104, 32'h552233AA, 2'b00);

      // Outstanding-read limit and ordering
      for (int i = 0; i < 5; i++) do_write("wfill", 32'h200 + 4 * i, 32'hA0A0_0000 + i, 4'hF, 2'b00);
      rready = 1'b0; arvalid = 1'b1; araddr = 32'h200;
      for (int i = 0; i < 4; i++) begin
         check("fill_arready", 64'(arready), 64'd1);
         @(negedge clk);
         araddr = araddr + 32'd4;
      end
      check("full_arready", 64'(arready), 64'd0);
      repeat (2) @(negedge clk);
      check("full_arready_hold", 64'(arready), 64'd0);
      check("full_rvalid", 64'(rvalid), 64'd1);
      check("full_head", 64'(rdata), 64'hA0A0_0000);
      rready = 1'b1;
      @(negedge clk);
      rready = 1'b0;
      check("pop_arready", 64'(arready), 64'd1);
      check("pop_head", 64'(rdata), 64'hA0A0_0001);
      @(negedge clk);
      arvalid = 1'b0;
      check("refill_arready", 64'(arready), 64'd0);
      base = 1;
      for (int i = 0; i < 4; i++) begin
         waited = 0;
         while (!rvalid && waited < 20) begin @(negedge clk); waited++; end
         check("drain_data", 64'(rdata), 64'(32'hA0A0_0000 + base + i));
         rready = 1'b1;
         @(negedge clk);
         rready = 1'b0;
      end
      check("drain_empty", 64'({rvalid, arready}), 64'b01);

      // Out-of-range access
      do_write("w0", 32'h0, 32'h0BADF00D, 4'hF, 2'b00);
      check("pre_err", 64'(err_oob), 64'd0);
      do_write("woob", 32'h3000_0000, 32'h0000_0055, 4'hF, 2'b10);
      check("err_oob_w", 64'(err_oob), 64'd1);
      do_read("r0", 32'h0, 32'h0BADF00D, 2'b00);
      do_read("roob", 32'h3000_0000, 32'h0, 2'b10);

      // Console and pass words
      do_write("wcon", 32'h1000_0000, 32'h0000_0041, 4'hF, 2'b00);
      repeat (2) @(negedge clk);
      check("con_pulses", 64'(con_cnt), 64'd1);
      check("con_char", 64'(con_last), 64'h41);
      do_read("rcon", 32'h1000_0000, 32'h0, 2'b00);
      do_write("wpass_bad", 32'h2000_0000, 32'h1234_5678, 4'hF, 2'b00);
      check("pass_bad", 64'(tests_passed), 64'd0);
      do_write("wpass", 32'h2000_0000, 32'd123456789, 4'hF, 2'b00);
      check("pass_set", 64'(tests_passed), 64'd1);
      do_read("rpass", 32'h2000_0000, 32'h1, 2'b00);

      // Reset with reads outstanding and a half-captured write
      rready = 1'b0; arvalid = 1'b1; araddr = 32'h100;
      repeat (3) @(negedge clk);
      arvalid = 1'b0;
      awvalid = 1'b1; awaddr = 32'h300;
      @(negedge clk);
      awvalid = 1'b0;
      check("mid_awheld", 64'({awready, wready, rvalid}), 64'b011);
      #2 resetn = 1'b0;
      #1;
      check("mid_valids", 64'({rvalid, bvalid}), 64'b00);
      check("mid_readies", 64'({awready, wready, arready}), 64'b111);
      @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
      do_read("r_after", 32'h100, 32'hDEADBEEF, 2'b00);
      do_write("w300", 32'h300, 32'h0000_0077, 4'hF, 2'b00);
      do_read("r300", 32'h300, 32'h0000_0077, 2'b00);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/axi4l_sram_slave.md
# axi4l_sram_slave

Parametrised AXI4-Lite slave memory for PicoRV32 simulation and FPGA bring-up. It replaces the fixed 32-bit behavioural memory model with a synthesizable, clocked RAM. It adds configurable data width, depth, read latency and outstanding-read buffering. It returns AXI error responses instead of halting the simulation, and keeps the console and test-pass MMIO words.

## Interface
Parameters:
- DATA_W, 32: data width; 32 or 64.
- ADDR_W, 32: address width.
- MEM_BYTES, 131072: RAM size in bytes; power of two.
- RD_LAT, 1: cycles from AR handshake to data in read buffer; 1..4.
- RD_DEPTH, 4: maximum outstanding reads, counting in-flight and buffered; 2..8.
- CONSOLE_ADDR, 32'h1000_0000: console output word.
- PASS_ADDR, 32'h2000_0000: test-pass word.
- PASS_MAGIC, 32'd123456789: value that sets tests_passed.

Ports:
- clk  in  1  sole clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- awvalid/awready  in/out  1  write address handshake; awaddr  in  ADDR_W; awprot  in  3 (ignored).
- wvalid/wready  in/out  1; wdata  in  DATA_W; wstrb  in  DATA_W/8.
- bvalid/bready  out/in  1; bresp  out  2.
- arvalid/arready  in/out  1; araddr  in  ADDR_W; arprot  in  3 (ignored).
- rvalid/rready  out/in  1; rdata  out  DATA_W; rresp  out  2.
- console_valid  out  1  one-cycle pulse per console write.
- console_char  out  8  byte written to the console.
- tests_passed  out  1  sticky.
- err_oob  out  1  sticky; any SLVERR issued.

## Operation
- Reset values: awready=1, wready=1, arready=1, bvalid=0, rvalid=0, bresp=0, rresp=0, rdata=0, console_valid=0, console_char=0, tests_passed=0, err_oob=0. RAM contents are not reset.
- Write path, FSM W_IDLE / W_HAVE_AW / W_HAVE_W / W_RESP:
  - AW and W are captured independently in holding registers. awready=0 while an address is held; wready=0 while data is held.
  - When both are held, the write commits on the next edge and the FSM enters W_RESP with bvalid=1.
  - Returns to W_IDLE on the bvalid&&bready edge.
- Commit decode, by address:
  - addr < MEM_BYTES: byte-strobed write to RAM word addr>>log2(DATA_W/8); bresp=OKAY.
  - CONSOLE_ADDR: console_char=wdata[7:0], console_valid pulses; OKAY.
  - PASS_ADDR: tests_passed=1 if wdata[31:0]==PASS_MAGIC; OKAY either way.
  - Any other address: no side effect; bresp=SLVERR(2'b10); err_oob=1.
- Read path:
  - AR is accepted when outstanding < RD_DEPTH, so arready=(outstanding<RD_DEPTH).
  - The accepted request flows through an RD_LAT-stage pipeline into a RD_DEPTH-entry FIFO. rvalid = FIFO not empty.
  - Entries pop on rvalid&&rready. Responses keep AR order.
- Read decode, by address:
  - RAM: word data, OKAY.
  - PASS_ADDR: {0, tests_passed}, OKAY.
  - CONSOLE_ADDR: 0, OKAY.
  - Other: rdata=0, SLVERR, err_oob=1.
- Address bits below the word width are ignored. Unaligned addresses are not faulted.
- Arithmetic: outstanding is a log2(RD_DEPTH)+1-bit counter. It increments on AR handshake and decrements on R handshake; both in the same cycle leave it unchanged.

## Timing
- Write: the later of the AW/W handshakes at edge N gives commit and bvalid=1 after edge N+1. The earliest back-to-back write accepts at edge N+2 after bready.
- Read: AR handshake at edge N gives rvalid after edge N+RD_LAT with no backpressure. Full throughput is one read per cycle when rready=1.
- Full: with outstanding==RD_DEPTH, arready=0 from the next cycle. If a pop and a push occur in the same cycle at full, the push is still refused, because arready was already low.
- Read/write hazard: RAM is sampled at the AR handshake edge. A write committing on that same edge is not visible; the read returns old data.
- Handshake rule: valid outputs are held stable until their ready is seen; data does not change while valid && !ready.
- Reset mid-operation: all in-flight reads and held writes are dropped. bvalid and rvalid fall asynchronously.

## Configuration
- AXI4L_SRAM_RAND_STALL_EN defined: a 64-bit xorshift register, seed 64'd88172645463325252, advances every cycle.
  - Bits [2:0] independently force awready, wready and arready low that cycle.
  - Bit 3 stalls FIFO pop, holding rvalid low.
  - Bit 4 delays write commit by one cycle.
  - Handshake rules above still hold.
- Undefined: no stalls; latencies are exactly those given in Timing.

## Structure
- Package axi4l_sram_pkg holds:
  - resp_t enum: OKAY=2'b00, SLVERR=2'b10.
  - Write FSM state enum.
  - Default CONSOLE_ADDR, PASS_ADDR and PASS_MAGIC constants.
  - Read-buffer entry struct {data, resp}.
- One sub-module: axi4l_rd_fifo, a parametrised synchronous FIFO with DEPTH, a payload type, and full/empty/count outputs. The RAM array and both channel paths stay in the top module.

## Test plan
- Reset, then write 32'hDEADBEEF to 0x100 with wstrb=4'hF, then read 0x100 → bresp=OKAY, rdata=32'hDEADBEEF, rresp=OKAY.
- Write 32'h000000AA to 0x104 with wstrb=4'b0001 over prior 32'h11223344, then read → 32'h112233AA.
- Issue RD_DEPTH=4 ARs with rready=0 → 5th arready=0; each pop lets exactly one more AR in; data order is preserved.
- Write to 0x3000_0000 → bresp=SLVERR, err_oob=1, RAM unchanged. Read from 0x3000_0000 → rresp=SLVERR, rdata=0.
- Write 0x41 to CONSOLE_ADDR → console_valid pulses once with console_char=8'h41. Write 123456789 to PASS_ADDR → tests_passed=1; a read of PASS_ADDR returns 1.
- Assert resetn low while 3 reads are outstanding and a write is half-captured → rvalid=0, bvalid=0, all readies=1. A new read after release completes normally.
